// File: rtl/spiflash_target.sv
// SPI flash responder (0x03 read, 0x9F JEDEC ID, 0xB9/0xAB power-down) serving a byte-wide synchronous memory.
// Bus pin changes act 3 clk later; no backpressure: mem_rdata is captured 1 clk after the mem_rd strobe.
module spiflash_target #(
    parameter int          ADDR_BITS = 24,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_csb,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_rdata,
    output logic                 powered_down
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, IGNORE} state_t;
    state_t state, state_nxt;

    logic [1:0]  csb_sync, sclk_sync, mosi_sync;
    logic        sclk_d;
    logic        csb_s, mosi_s, sclk_rise, sclk_fall;
    logic [2:0]  bit_cnt;
    logic [4:0]  addr_cnt;
    logic [22:0] in_sh;
    logic [7:0]  opcode;
    logic [23:0] addr_full;
    logic [7:0]  tx_sh;
    logic [1:0]  id_cnt;
    logic [7:0]  id_byte;
    logic        rd_d;

    // csb synchronizer resets to "selected": a reset released mid-transaction
    // sits in IGNORE until the bus is seen deselected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_sync  <= 2'b00;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
        end else begin
            csb_sync  <= {csb_sync[0], spi_csb};
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign csb_s     = csb_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign opcode    = {in_sh[6:0], mosi_s};
    assign addr_full = {in_sh, mosi_s};

    always_comb begin
        id_byte = 8'h00;
        case (id_cnt)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IGNORE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csb_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: if (sclk_rise && bit_cnt == 3'd7) begin
                    if (powered_down)         state_nxt = IGNORE;
                    else if (opcode == 8'h03) state_nxt = ADDR;
                    else if (opcode == 8'h9F) state_nxt = ID;
                    else                      state_nxt = IGNORE;
                end
                ADDR: if (sclk_rise && addr_cnt == 5'd23) state_nxt = DATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt      <= '0;
            addr_cnt     <= '0;
            in_sh        <= '0;
            tx_sh        <= '0;
            id_cnt       <= '0;
            rd_d         <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            powered_down <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            rd_d   <= mem_rd;
            if (rd_d) tx_sh <= mem_rdata;
            if (csb_s) begin
                bit_cnt     <= '0;
                addr_cnt    <= '0;
                in_sh       <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    CMD: if (sclk_rise) begin
                        in_sh   <= {in_sh[21:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (opcode == 8'hAB)
                                powered_down <= 1'b0;
                            else if (opcode == 8'hB9 && !powered_down)
                                powered_down <= 1'b1;
                            if (opcode == 8'h9F && !powered_down) begin
                                tx_sh  <= JEDEC_ID[23:16];
                                id_cnt <= 2'd1;
                            end
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        in_sh    <= {in_sh[21:0], mosi_s};
                        addr_cnt <= addr_cnt + 5'd1;
                        if (addr_cnt == 5'd23) begin
                            mem_addr <= ADDR_BITS'(addr_full);
                            mem_rd   <= 1'b1;
                            bit_cnt  <= '0;
                        end
                    end
                    DATA: if (sclk_fall) begin
                        spi_miso    <= tx_sh[7];
                        spi_miso_oe <= 1'b1;
                        tx_sh       <= {tx_sh[6:0], 1'b0};
                        bit_cnt     <= bit_cnt + 3'd1;
                        // Last bit of the byte is out: prefetch the next byte before the next falling edge.
                        if (bit_cnt == 3'd7) begin
                            mem_addr <= mem_addr + ADDR_BITS'(1);
                            mem_rd   <= 1'b1;
                        end
                    end
                    ID: if (sclk_fall) begin
                        spi_miso    <= tx_sh[7];
                        spi_miso_oe <= 1'b1;
                        bit_cnt     <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_sh <= id_byte;
                            if (id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
                        end else begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                    end
                    IGNORE: spi_miso_oe <= 1'b0;
                    default: begin
                        bit_cnt  <= '0;
                        addr_cnt <= '0;
                        in_sh    <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spiflash_target.sv
// Bench for spiflash_target (ADDR_BITS=8): table of SPI transactions plus abort/reset sequences,
// with data bytes and mem_rd addresses scoreboarded through queues.
module tb_spiflash_target;
    localparam int AB = 8;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          spi_csb = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe, mem_rd, powered_down;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;

    int checks = 0;
    int failures = 0;
    logic [7:0]    exp_q[$];
    logic [AB-1:0] exp_addr_q[$];
    logic [AB-1:0] mon_e;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] data;
        logic        oe;
        logic        pd;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    spiflash_target #(.ADDR_BITS(AB), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .powered_down(powered_down)
    );

    // Synchronous memory whose contents equal the low address byte.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr;

    always @(negedge clk) begin
        if (resetn && mem_rd) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL mem_rd_unexpected actual_addr=%h required=no_read", mem_addr);
            end else begin
                mon_e = exp_addr_q.pop_front();
                if (mem_addr !== mon_e) begin
                    failures++;
                    $display("FAIL mem_addr actual=%h required=%h", mem_addr, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                        output logic oe_all, output logic oe_any);
        rx = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(H);
            rx[i] = spi_miso;
            oe_all &= spi_miso_oe;
            oe_any |= spi_miso_oe;
            spi_clk = 1'b1;
            tick(H);
            spi_clk = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [23:0] addr, input int n,
                                input logic [31:0] data, input logic oe, input logic pd);
        vec_t v;
        v.op = op; v.addr = addr; v.nbytes = n; v.data = data; v.oe = oe; v.pd = pd;
        return v;
    endfunction

    task automatic run_vec(input int k);
        vec_t v;
        logic [7:0] rx, e;
        logic all1, any1;
        v = vecs[k];
        if (v.oe) begin
            for (int i = 0; i < v.nbytes; i++) exp_q.push_back(v.data[31-8*i -: 8]);
            // A read also prefetches the byte after the last one clocked out.
            if (v.op == 8'h03)
                for (int i = 0; i <= v.nbytes; i++) exp_addr_q.push_back(AB'(v.addr + 24'(i)));
        end
        spi_csb = 1'b0;
        tick(H);
        xfer(v.op, 8, rx, all1, any1);
        if (v.op == 8'h03)
            for (int b = 2; b >= 0; b--) xfer(v.addr[8*b +: 8], 8, rx, all1, any1);
        for (int i = 0; i < v.nbytes; i++) begin
            xfer(8'h00, 8, rx, all1, any1);
            if (v.oe) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d_byte%0d", k, i), {24'h0, rx}, {24'h0, e});
                check($sformatf("vec%0d_oe%0d", k, i), {31'h0, all1}, 32'd1);
            end else begin
                check($sformatf("vec%0d_oe_low%0d", k, i), {31'h0, any1}, 32'd0);
            end
        end
        tick(H);
        spi_csb = 1'b1;
        tick(H);
        check($sformatf("vec%0d_powered_down", k), {31'h0, powered_down}, {31'h0, v.pd});
        check($sformatf("vec%0d_rd_remaining", k), exp_addr_q.size(), 32'd0);
        exp_addr_q.delete();
    endtask

    initial begin
        logic [7:0] rx;
        logic all1, any1;

        vecs[0]  = mk(8'h03, 24'h000010, 3, 32'h10111200, 1'b1, 1'b0);
        vecs[1]  = mk(8'h9F, 24'h000000, 4, 32'hEF401600, 1'b1, 1'b0);
        vecs[2]  = mk(8'h03, 24'h0000FF, 3, 32'hFF000100, 1'b1, 1'b0);
        vecs[3]  = mk(8'h03, 24'hABCD80, 2, 32'h80810000, 1'b1, 1'b0);
        vecs[4]  = mk(8'h5A, 24'h000000, 2, 32'h00000000, 1'b0, 1'b0);
        vecs[5]  = mk(8'hB9, 24'h000000, 1, 32'h00000000, 1'b0, 1'b1);
        vecs[6]  = mk(8'h03, 24'h000010, 2, 32'h00000000, 1'b0, 1'b1);
        vecs[7]  = mk(8'h9F, 24'h000000, 1, 32'h00000000, 1'b0, 1'b1);
        vecs[8]  = mk(8'hAB, 24'h000000, 1, 32'h00000000, 1'b0, 1'b0);
        vecs[9]  = mk(8'h03, 24'h000010, 2, 32'h10110000, 1'b1, 1'b0);
        vecs[10] = mk(8'h9F, 24'h000000, 4, 32'hEF401600, 1'b1, 1'b0);

        tick(2);
        check("rst_miso", {31'h0, spi_miso}, 32'd0);
        check("rst_oe", {31'h0, spi_miso_oe}, 32'd0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        check("rst_pd", {31'h0, powered_down}, 32'd0);
        resetn = 1'b1;
        tick(4);

        for (int k = 0; k < 11; k++) run_vec(k);

        // Abort after 13 address bits, then an ID read must still work.
        spi_csb = 1'b0;
        tick(H);
        xfer(8'h03, 8, rx, all1, any1);
        xfer(8'h00, 8, rx, all1, any1);
        xfer(8'h12, 5, rx, all1, any1);
        spi_csb = 1'b1;
        tick(3);
        check("abort_addr_oe", {31'h0, spi_miso_oe}, 32'd0);
        tick(H);
        run_vec(1);

        // Unknown opcode followed by more clocks stays silent.
        spi_csb = 1'b0;
        tick(H);
        xfer(8'h5A, 8, rx, all1, any1);
        xfer(8'hFF, 8, rx, all1, any1);
        check("unknown_oe_low", {31'h0, any1}, 32'd0);
        spi_csb = 1'b1;
        tick(H);
        run_vec(1);

        // Abort in the middle of an ID byte: output enable drops exactly 3 clk after csb rises.
        spi_csb = 1'b0;
        tick(H);
        xfer(8'h9F, 8, rx, all1, any1);
        xfer(8'h00, 8, rx, all1, any1);
        check("id_abort_byte0", {24'h0, rx}, 32'h000000EF);
        xfer(8'h00, 3, rx, all1, any1);
        spi_csb = 1'b1;
        tick(2);
        check("id_abort_oe_hold", {31'h0, spi_miso_oe}, 32'd1);
        tick(1);
        check("id_abort_oe_drop", {31'h0, spi_miso_oe}, 32'd0);
        tick(H);

        // Reset during byte 2 of a read, released with csb still low.
        exp_addr_q.push_back(8'h40);
        exp_addr_q.push_back(8'h41);
        spi_csb = 1'b0;
        tick(H);
        xfer(8'h03, 8, rx, all1, any1);
        xfer(8'h00, 8, rx, all1, any1);
        xfer(8'h00, 8, rx, all1, any1);
        xfer(8'h40, 8, rx, all1, any1);
        xfer(8'h00, 8, rx, all1, any1);
        check("rstmid_byte0", {24'h0, rx}, 32'h00000040);
        xfer(8'h00, 4, rx, all1, any1);
        check("rstmid_oe_before", {31'h0, spi_miso_oe}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rstmid_miso", {31'h0, spi_miso}, 32'd0);
        check("rstmid_oe", {31'h0, spi_miso_oe}, 32'd0);
        check("rstmid_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("rstmid_mem_addr", {24'h0, mem_addr}, 32'd0);
        check("rstmid_pd", {31'h0, powered_down}, 32'd0);
        check("rstmid_prefetch_seen", exp_addr_q.size(), 32'd0);
        tick(3);
        resetn = 1'b1;
        xfer(8'h00, 4, rx, all1, any1);
        xfer(8'h9F, 8, rx, all1, any1);
        check("rstmid_ignore_oe0", {31'h0, any1}, 32'd0);
        xfer(8'h03, 8, rx, all1, any1);
        check("rstmid_ignore_oe1", {31'h0, any1}, 32'd0);
        spi_csb = 1'b1;
        tick(H);
        run_vec(10);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
